// File: rtl/avalon_timer_irq.sv
// 64-bit memory-mapped timer on an Avalon-MM slave: prescaled MTIME counter,
// MTIMECMP compare, sticky PENDING status and a registered level interrupt.
module avalon_timer_irq #(
  parameter int ADDR_WIDTH     = 2,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] avs_address,
  input  logic [7:0]            avs_byteenable,
  input  logic                  avs_read,
  output logic [63:0]           avs_readdata,
  output logic                  avs_readdatavalid,
  input  logic                  avs_write,
  input  logic [63:0]           avs_writedata,
  output logic                  avs_waitrequest,
  output logic                  irq
);

  localparam logic [1:0] A_MTIME    = 2'd0;
  localparam logic [1:0] A_MTIMECMP = 2'd1;
  localparam logic [1:0] A_CONTROL  = 2'd2;
  localparam logic [1:0] A_STATUS   = 2'd3;

  localparam logic [63:0] CTRL_MASK =
    (((64'd1 << PRESCALE_WIDTH) - 64'd1) << 16) | 64'd7;

  logic                      r_wait;
  logic                      r_rvalid;
  logic [63:0]               r_rdata;
  logic [63:0]               r_mtime;
  logic [63:0]               r_mtimecmp;
  logic [63:0]               r_ctrl;
  logic [PRESCALE_WIDTH-1:0] r_presc;
  logic                      r_pending;
  logic                      r_irq;

  logic                      w_en;
  logic                      w_ie;
  logic                      w_reload;
  logic [PRESCALE_WIDTH-1:0] w_prescale;
  logic [1:0]                w_sel;
  logic                      w_wr;
  logic                      w_rd;
  logic                      w_ge;
  logic                      w_match;
  logic                      w_tick;
  logic                      w_w1c;
  logic [63:0]               w_mtime_ticked;
  logic [63:0]               w_mtime_next;
  logic [63:0]               w_cmp_next;
  logic [63:0]               w_ctrl_next;
  logic [63:0]               w_rd_mux;

  assign w_en       = r_ctrl[0];
  assign w_ie       = r_ctrl[1];
  assign w_reload   = r_ctrl[2];
  assign w_prescale = r_ctrl[16 +: PRESCALE_WIDTH];
  assign w_sel      = avs_address[1:0];

  // Handshake: a request is accepted on any edge where waitrequest is low.
  // Reads answer exactly one cycle later; a read issued together with a write
  // is dropped and only the write is performed.
  assign w_wr = avs_write & ~r_wait;
  assign w_rd = avs_read & ~avs_write & ~r_wait;

  assign w_ge    = (r_mtime >= r_mtimecmp);
  assign w_match = w_en & w_ge;
  assign w_tick  = w_en & (r_presc == w_prescale);
  assign w_w1c   = w_wr & (w_sel == A_STATUS) & avs_byteenable[0] & avs_writedata[0];

  assign w_mtime_ticked = !w_tick ? r_mtime :
                          (w_reload && w_ge) ? 64'd0 : r_mtime + 64'd1;

  // Written lanes override the ticked value lane by lane.
  always_comb begin
    w_mtime_next = w_mtime_ticked;
    w_cmp_next   = r_mtimecmp;
    w_ctrl_next  = r_ctrl;
    for (int i = 0; i < 8; i++) begin
      if (w_wr && avs_byteenable[i]) begin
        case (w_sel)
          A_MTIME:    w_mtime_next[8*i +: 8] = avs_writedata[8*i +: 8];
          A_MTIMECMP: w_cmp_next[8*i +: 8]   = avs_writedata[8*i +: 8];
          A_CONTROL:  w_ctrl_next[8*i +: 8]  = avs_writedata[8*i +: 8];
          default:    ;
        endcase
      end
    end
    w_ctrl_next = w_ctrl_next & CTRL_MASK;
  end

  always_comb begin
    w_rd_mux = 64'd0;
    case (w_sel)
      A_MTIME:    w_rd_mux = r_mtime;
      A_MTIMECMP: w_rd_mux = r_mtimecmp;
      A_CONTROL:  w_rd_mux = r_ctrl;
      A_STATUS:   w_rd_mux = {63'd0, r_pending};
      default:    w_rd_mux = 64'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait     <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rdata    <= 64'd0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= '1;
      r_ctrl     <= 64'd0;
      r_presc    <= '0;
      r_pending  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_wait     <= 1'b0;
      r_rvalid   <= w_rd;
      if (w_rd) r_rdata <= w_rd_mux;
      r_mtime    <= w_mtime_next;
      r_mtimecmp <= w_cmp_next;
      r_ctrl     <= w_ctrl_next;
      if (!w_en || w_tick) r_presc <= '0;
      else                 r_presc <= r_presc + 1'b1;
      // A match in the same cycle as a W1C keeps PENDING set.
      r_pending  <= w_match | (r_pending & ~w_w1c);
      r_irq      <= r_pending & w_ie;
    end
  end

  assign avs_waitrequest   = r_wait;
  assign avs_readdatavalid = r_rvalid;
  assign avs_readdata      = r_rdata;
  assign irq               = r_irq;

endmodule

// File: tb/tb_avalon_timer_irq.sv
// Directed bench for avalon_timer_irq: read responses go through an expected
// queue checked by a monitor; irq/waitrequest are checked inline.
module tb_avalon_timer_irq;

  logic        clock;
  logic        reset;
  logic [1:0]  avs_address;
  logic [7:0]  avs_byteenable;
  logic        avs_read;
  logic [63:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_write;
  logic [63:0] avs_writedata;
  logic        avs_waitrequest;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] exp_q[$];
  int          cyc_q[$];

  avalon_timer_irq #(.ADDR_WIDTH(2), .PRESCALE_WIDTH(16)) dut (
    .clock             (clock),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_byteenable    (avs_byteenable),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_waitrequest   (avs_waitrequest),
    .irq               (irq)
  );

  // Clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected got=%h exp=none", avs_readdata);
      end else begin
        logic [63:0] e;
        int c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("rd_data", avs_readdata, e);
        chk("rd_latency", 64'(cyc), 64'(c));
      end
    end
  end

  // Driver tasks: each occupies exactly one clock edge, entered #1 after a posedge
  task automatic rd(input logic [1:0] a, input logic [63:0] e);
    avs_read    = 1'b1;
    avs_address = a;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 1);
    @(posedge clock); #1;
    avs_read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d, input logic [7:0] be);
    avs_write      = 1'b1;
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    @(posedge clock); #1;
    avs_write      = 1'b0;
    avs_byteenable = 8'h00;
  endtask

  task automatic rdwr(input logic [1:0] a, input logic [63:0] d);
    avs_read       = 1'b1;
    avs_write      = 1'b1;
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = 8'hFF;
    @(posedge clock); #1;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_byteenable = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset          = 1'b1;
    avs_address    = 2'd0;
    avs_byteenable = 8'h00;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = 64'd0;

    // Reset state and waitrequest window
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rvalid", 64'(avs_readdatavalid), 64'd0);
    chk("rst_rdata", avs_readdata, 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_wait", 64'(avs_waitrequest), 64'd1);
    reset       = 1'b0;
    avs_read    = 1'b1;
    avs_address = 2'd1;
    @(negedge clock);
    chk("wait_first", 64'(avs_waitrequest), 64'd1);
    @(posedge clock); #1;
    chk("wait_clear", 64'(avs_waitrequest), 64'd0);
    rd(2'd1, 64'hFFFF_FFFF_FFFF_FFFF);

    // Free-running count, PENDING and irq timing
    wr(2'd1, 64'd10, 8'hFF);
    wr(2'd2, 64'h3, 8'hFF);
    for (int i = 0; i < 12; i++) begin
      rd(2'd0, 64'(i));
      chk("irq_count", 64'(irq), (i >= 11) ? 64'd1 : 64'd0);
    end
    rd(2'd3, 64'd1);
    wr(2'd2, 64'h2, 8'hFF);
    rd(2'd0, 64'd14);
    rd(2'd2, 64'd2);
    chk("irq_en_off", 64'(irq), 64'd1);

    // Periodic reload with PRESCALE=2
    wr(2'd0, 64'd0, 8'hFF);
    wr(2'd1, 64'd4, 8'hFF);
    wr(2'd3, 64'd1, 8'hFF);
    wr(2'd2, 64'h0002_0007, 8'hFF);
    for (int j = 1; j <= 18; j++) begin
      rd(2'd0, 64'(((j - 1) / 3) % 5));
      chk("irq_reload", 64'(irq), (j >= 14) ? 64'd1 : 64'd0);
    end
    wr(2'd3, 64'd1, 8'hFF);
    rd(2'd3, 64'd0);
    idle(7);
    rd(2'd3, 64'd0);
    rd(2'd3, 64'd1);
    rd(2'd0, 64'd4);
    rd(2'd0, 64'd0);

    // Byte-lane writes colliding with a tick
    wr(2'd2, 64'd0, 8'hFF);
    wr(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(2'd0, 64'd5, 8'hFF);
    wr(2'd3, 64'd1, 8'hFF);
    wr(2'd2, 64'd1, 8'hFF);
    wr(2'd0, 64'hAB, 8'h01);
    rd(2'd0, 64'hAB);
    wr(2'd2, 64'd0, 8'hFF);
    wr(2'd0, 64'd5, 8'hFF);
    wr(2'd2, 64'd1, 8'hFF);
    wr(2'd0, 64'hCD00, 8'h02);
    rd(2'd0, 64'hCD06);
    wr(2'd2, 64'd0, 8'hFF);
    wr(2'd0, 64'hFFFF, 8'h00);
    rd(2'd0, 64'hCD08);
    rdwr(2'd1, 64'd1000);
    rd(2'd1, 64'd1000);
    wr(2'd2, 64'hFFFF_FFFF_FFFF_FFF8, 8'hFF);
    rd(2'd2, 64'hFFFF_0000);
    idle(2);
    chk("rd_hold", avs_readdata, 64'hFFFF_0000);
    chk("rvalid_idle", 64'(avs_readdatavalid), 64'd0);
    wr(2'd2, 64'd0, 8'hFF);

    // W1C of PENDING: on a match cycle, then after match ends
    wr(2'd2, 64'h3, 8'hFF);
    idle(2);
    chk("irq_match", 64'(irq), 64'd1);
    wr(2'd3, 64'd1, 8'hFF);
    rd(2'd3, 64'd1);
    wr(2'd0, 64'd0, 8'hFF);
    wr(2'd3, 64'd1, 8'hFF);
    chk("irq_w1c_lag", 64'(irq), 64'd1);
    rd(2'd3, 64'd0);
    chk("irq_w1c", 64'(irq), 64'd0);

    // Reset during an outstanding read
    wr(2'd1, 64'd10, 8'hFF);
    wr(2'd0, 64'd50, 8'hFF);
    idle(2);
    chk("irq_pre_rst", 64'(irq), 64'd1);
    avs_read    = 1'b1;
    avs_address = 2'd0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_mid_irq", 64'(irq), 64'd0);
    chk("rst_mid_rvalid", 64'(avs_readdatavalid), 64'd0);
    chk("rst_mid_wait", 64'(avs_waitrequest), 64'd1);
    @(posedge clock); #1;
    chk("rst_mid_rvalid2", 64'(avs_readdatavalid), 64'd0);
    avs_read = 1'b0;
    reset    = 1'b0;
    idle(1);
    rd(2'd0, 64'd0);
    rd(2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(2'd2, 64'd0);
    rd(2'd3, 64'd0);
    idle(3);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
